// File: rtl/paddle_debouncer.sv
// ============================================================================
//  Module      : paddle_debouncer
//  Description : Two-channel pushbutton synchronizer/debouncer producing a
//                one-cycle trigger pulse and a debounced held level per button.
//                Optional macro DBNC_LOCKOUT_EN adds a per-channel retrigger lockout.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module paddle_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SYNC_STAGES     = 2,
    parameter int LOCKOUT_CYCLES  = 5000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_left_raw,
    input  logic btn_right_raw,
    output logic left_trigger,
    output logic right_trigger,
    output logic left_held,
    output logic right_held
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] C_DBNC = CW'(DEBOUNCE_CYCLES);

    localparam logic [1:0] S_IDLE         = 2'd0;
    localparam logic [1:0] S_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] S_HELD         = 2'd2;
    localparam logic [1:0] S_RELEASE_WAIT = 2'd3;

    if (DEBOUNCE_CYCLES < 1 || SYNC_STAGES < 2 || LOCKOUT_CYCLES < 0) begin : g_param_check
        $error("paddle_debouncer: illegal parameter value");
    end

    logic [1:0] w_raw;
    logic [1:0] w_trig;
    logic [1:0] w_held;

    assign w_raw = {btn_right_raw, btn_left_raw};

    for (genvar g = 0; g < 2; g++) begin : g_chan
        logic [SYNC_STAGES-1:0] r_sync;
        logic [1:0]             r_state;
        logic [1:0]             w_state_nxt;
        logic [CW-1:0]          r_cnt;
        logic [CW-1:0]          w_cnt_nxt;
        logic                   r_trig;
        logic                   w_s;
        logic                   w_accept;
        logic                   w_fire;
        logic                   w_lock_busy;

        assign w_s = r_sync[SYNC_STAGES-1];

        // State register; the trigger is registered so it can never glitch.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_sync  <= '0;
                r_state <= S_IDLE;
                r_cnt   <= '0;
                r_trig  <= 1'b0;
            end else begin
                r_sync  <= {r_sync[SYNC_STAGES-2:0], w_raw[g]};
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_trig  <= w_fire;
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_accept    = 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_s) begin
                        w_state_nxt = S_PRESS_WAIT;
                        w_cnt_nxt   = CW'(1);
                    end else begin
                        w_cnt_nxt   = '0;
                    end
                end
                S_PRESS_WAIT: begin
                    if (!w_s) begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == C_DBNC) begin
                        w_state_nxt = S_HELD;
                        w_cnt_nxt   = '0;
                        w_accept    = 1'b1;
                    end else if (r_cnt < C_DBNC) begin
                        w_cnt_nxt   = r_cnt + CW'(1);
                    end
                end
                S_HELD: begin
                    if (!w_s) begin
                        w_state_nxt = S_RELEASE_WAIT;
                        w_cnt_nxt   = CW'(1);
                    end
                end
                default: begin
                    if (w_s) begin
                        w_state_nxt = S_HELD;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == C_DBNC) begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt < C_DBNC) begin
                        w_cnt_nxt   = r_cnt + CW'(1);
                    end
                end
            endcase
        end

        always_comb begin
            w_fire    = w_accept & ~w_lock_busy;
            w_held[g] = (r_state == S_HELD) || (r_state == S_RELEASE_WAIT);
            w_trig[g] = r_trig;
        end

`ifdef DBNC_LOCKOUT_EN
        localparam int LW = $clog2(LOCKOUT_CYCLES + 2);
        logic [LW-1:0] r_lock;

        // Suppressed presses do not reload the lockout window.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_lock <= '0;
            end else if (w_fire) begin
                r_lock <= LW'(LOCKOUT_CYCLES);
            end else if (r_lock != '0) begin
                r_lock <= r_lock - LW'(1);
            end
        end

        assign w_lock_busy = (r_lock != '0);
`else
        assign w_lock_busy = 1'b0;
`endif
    end

    assign left_trigger  = w_trig[0];
    assign right_trigger = w_trig[1];
    assign left_held     = w_held[0];
    assign right_held    = w_held[1];

endmodule

`default_nettype wire

// File: tb/tb_paddle_debouncer.sv
// ============================================================================
//  Module      : tb_paddle_debouncer
//  Description : Scoreboard bench: expected trigger cycles are queued when a
//                press is driven and matched against observed trigger pulses.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_paddle_debouncer;

    localparam int DBNC = 4;
    localparam int SYNC = 2;
    localparam int LAT  = SYNC + DBNC + 1;   // negedge-to-observed-trigger distance

    logic clk;
    logic reset;
    logic btn_left_raw;
    logic btn_right_raw;
    logic left_trigger;
    logic right_trigger;
    logic left_held;
    logic right_held;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;
    int q_left[$];
    int q_right[$];
    logic r_prev_l = 1'b0;
    logic r_prev_r = 1'b0;

    paddle_debouncer #(
        .DEBOUNCE_CYCLES(DBNC),
        .SYNC_STAGES    (SYNC),
        .LOCKOUT_CYCLES (20)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .btn_left_raw (btn_left_raw),
        .btn_right_raw(btn_right_raw),
        .left_trigger (left_trigger),
        .right_trigger(right_trigger),
        .left_held    (left_held),
        .right_held   (right_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Trigger monitor: every pulse must match the oldest queued cycle.
    always @(negedge clk) begin
        if (left_trigger) begin
            if (q_left.size() == 0) chk_eq("left_unexpected", 1, 0);
            else                    chk_eq("left_trig_cyc", cyc, q_left.pop_front());
            if (r_prev_l)           chk_eq("left_width", 2, 1);
        end else if (q_left.size() > 0 && q_left[0] < cyc) begin
            chk_eq("left_missed", cyc, q_left.pop_front());
        end
        if (right_trigger) begin
            if (q_right.size() == 0) chk_eq("right_unexpected", 1, 0);
            else                     chk_eq("right_trig_cyc", cyc, q_right.pop_front());
            if (r_prev_r)            chk_eq("right_width", 2, 1);
        end else if (q_right.size() > 0 && q_right[0] < cyc) begin
            chk_eq("right_missed", cyc, q_right.pop_front());
        end
        r_prev_l = left_trigger;
        r_prev_r = right_trigger;
    end

    initial begin
        reset         = 1'b1;
        btn_left_raw  = 1'b1;
        btn_right_raw = 1'b1;

        // Buttons held through reset: nothing may come out.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_eq("rst_outputs", {left_trigger, right_trigger, left_held, right_held}, 0);
        end
        reset = 1'b0;
        q_left.push_back(cyc + LAT);
        q_right.push_back(cyc + LAT);
        wait_cyc(10);
        chk_eq("t1_left_held", left_held, 1);
        chk_eq("t1_right_held", right_held, 1);
        btn_left_raw  = 1'b0;
        btn_right_raw = 1'b0;
        wait_cyc(10);
        chk_eq("t1_release", {left_held, right_held}, 0);

        // Clean left press, 12 cycles long, then release latency.
        btn_left_raw = 1'b1;
        q_left.push_back(cyc + LAT);
        wait_cyc(LAT);
        chk_eq("t2_held_rise", left_held, 1);
        wait_cyc(12 - LAT);
        btn_left_raw = 1'b0;
        wait_cyc(LAT - 1);
        chk_eq("t2_held_before_fall", left_held, 1);
        wait_cyc(1);
        chk_eq("t2_held_fall", left_held, 0);
        chk_eq("t2_right_quiet", right_held, 0);
        wait_cyc(5);

        // Bounce: 3 high / 1 low never reaches the stable count.
        for (int i = 0; i < 8; i++) begin
            btn_left_raw = 1'b1;
            wait_cyc(3);
            btn_left_raw = 1'b0;
            wait_cyc(1);
            chk_eq("t3_bounce_held", left_held, 0);
        end
        wait_cyc(10);
        chk_eq("t3_after_bounce", left_held, 0);

        // Simultaneous press on both channels.
        btn_left_raw  = 1'b1;
        btn_right_raw = 1'b1;
        q_left.push_back(cyc + LAT);
        q_right.push_back(cyc + LAT);
        wait_cyc(10);
        chk_eq("t4_both_held", {left_held, right_held}, 3);
        btn_left_raw  = 1'b0;
        btn_right_raw = 1'b0;
        wait_cyc(12);

        // Reset while right channel is two counts into its press debounce.
        btn_right_raw = 1'b1;
        wait_cyc(4);
        reset = 1'b1;
        wait_cyc(2);
        chk_eq("t5_rst_held", right_held, 0);
        reset = 1'b0;
        q_right.push_back(cyc + LAT);
        wait_cyc(LAT - 1);
        chk_eq("t5_restart_not_yet", right_held, 0);
        wait_cyc(3);
        chk_eq("t5_restart_held", right_held, 1);
        btn_right_raw = 1'b0;
        wait_cyc(30);

        // Re-press 10 cycles after a trigger (inside lockout when enabled).
        btn_left_raw = 1'b1;
        q_left.push_back(cyc + LAT);
        wait_cyc(LAT);
        btn_left_raw = 1'b0;
        wait_cyc(10);
        btn_left_raw = 1'b1;
`ifndef DBNC_LOCKOUT_EN
        q_left.push_back(cyc + LAT);
`endif
        wait_cyc(10);
        chk_eq("t6_short_held", left_held, 1);
        btn_left_raw = 1'b0;
        wait_cyc(30);

        // Re-press 25 cycles after a trigger: always accepted.
        btn_left_raw = 1'b1;
        q_left.push_back(cyc + LAT);
        wait_cyc(LAT);
        btn_left_raw = 1'b0;
        wait_cyc(25);
        btn_left_raw = 1'b1;
        q_left.push_back(cyc + LAT);
        wait_cyc(10);
        chk_eq("t6_long_held", left_held, 1);
        btn_left_raw = 1'b0;
        wait_cyc(12);
        chk_eq("t6_final_release", left_held, 0);

        chk_eq("left_pending", q_left.size(), 0);
        chk_eq("right_pending", q_right.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
